// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: valid tracking, stall hold, flush bubbles,
// destination-register resolution, load-use detection and saturating event counters.
module id_ex_pipe #(
  parameter int              XLEN      = 32,
  parameter int              REG_W     = 5,
  parameter int              OP_W      = 6,
  parameter logic [OP_W-1:0] NOP_OP    = 6'b111111,
  parameter int              MEMRD_BIT = 1,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_cnt_clr,
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rt,
  input  logic [REG_W-1:0] i_rd,
  input  logic [1:0]       i_ex,
  input  logic [2:0]       i_m,
  input  logic [1:0]       i_wb,
  input  logic [XLEN-1:0]  i_valA,
  input  logic [XLEN-1:0]  i_valB,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_pc_plus4,
  input  logic [OP_W-1:0]  i_operation,
  output logic [REG_W-1:0] o_rs,
  output logic [REG_W-1:0] o_rt,
  output logic [REG_W-1:0] o_rd,
  output logic [1:0]       o_ex,
  output logic [2:0]       o_m,
  output logic [1:0]       o_wb,
  output logic [XLEN-1:0]  o_valA,
  output logic [XLEN-1:0]  o_valB,
  output logic [XLEN-1:0]  o_imm,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic [OP_W-1:0]  o_operation,
  output logic [REG_W-1:0] o_dst,
  output logic             o_valid,
  output logic             o_load_use,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [OP_W-1:0]  OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0]  OP_ADDIU = OP_W'(6'b001001);
  localparam logic [OP_W-1:0]  OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0]  OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0]  OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0]  OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0]  OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0]  OP_JAL   = OP_W'(6'b000011);
  localparam logic [REG_W-1:0] REG_RA   = REG_W'(5'd31);
  localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
  localparam logic [XLEN-1:0]  XZERO    = {XLEN{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } act_e;

  act_e act_s;

  logic [REG_W-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q, dst_d, dst_q;
  logic [1:0]       ex_d, ex_q, wb_d, wb_q;
  logic [2:0]       m_d, m_q;
  logic [XLEN-1:0]  vala_d, vala_q, valb_d, valb_q, imm_d, imm_q, pc4_d, pc4_q;
  logic [OP_W-1:0]  op_d, op_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // I-type ALU ops and loads write rt, jal writes the link register, the rest write rd.
  function automatic logic [REG_W-1:0] resolve_dst(input logic [OP_W-1:0]  op,
                                                   input logic [REG_W-1:0] rt,
                                                   input logic [REG_W-1:0] rd);
    logic [REG_W-1:0] r;
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: r = rt;
      OP_JAL:  r = REG_RA;
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  always_comb begin
    act_s = ACT_HOLD;
    if (i_flush) begin
      act_s = ACT_BUBBLE;
    end else if (i_stall) begin
      act_s = ACT_HOLD;
    end else if (i_valid) begin
      act_s = ACT_LOAD;
    end else begin
      act_s = ACT_BUBBLE;
    end
  end

  always_comb begin
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ex_d    = ex_q;
    m_d     = m_q;
    wb_d    = wb_q;
    vala_d  = vala_q;
    valb_d  = valb_q;
    imm_d   = imm_q;
    pc4_d   = pc4_q;
    op_d    = op_q;
    dst_d   = dst_q;
    valid_d = valid_q;
    case (act_s)
      ACT_LOAD: begin
        rs_d    = i_rs;
        rt_d    = i_rt;
        rd_d    = i_rd;
        ex_d    = i_ex;
        m_d     = i_m;
        wb_d    = i_wb;
        vala_d  = i_valA;
        valb_d  = i_valB;
        imm_d   = i_imm;
        pc4_d   = i_pc_plus4;
        op_d    = i_operation;
        dst_d   = resolve_dst(i_operation, i_rt, i_rd);
        valid_d = 1'b1;
      end
      ACT_BUBBLE: begin
        rs_d    = REG_ZERO;
        rt_d    = REG_ZERO;
        rd_d    = REG_ZERO;
        ex_d    = 2'b00;
        m_d     = 3'b000;
        wb_d    = 2'b00;
        vala_d  = XZERO;
        valb_d  = XZERO;
        imm_d   = XZERO;
        pc4_d   = XZERO;
        op_d    = NOP_OP;
        dst_d   = REG_ZERO;
        valid_d = 1'b0;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  // A flush counts only as a flush, even when a stall is requested on the same edge.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = CNT_ZERO;
      flush_cnt_d = CNT_ZERO;
    end else if (i_flush) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (i_stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q        <= REG_ZERO;
      rt_q        <= REG_ZERO;
      rd_q        <= REG_ZERO;
      ex_q        <= 2'b00;
      m_q         <= 3'b000;
      wb_q        <= 2'b00;
      vala_q      <= XZERO;
      valb_q      <= XZERO;
      imm_q       <= XZERO;
      pc4_q       <= XZERO;
      op_q        <= NOP_OP;
      dst_q       <= REG_ZERO;
      valid_q     <= 1'b0;
      stall_cnt_q <= CNT_ZERO;
      flush_cnt_q <= CNT_ZERO;
    end else begin
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      ex_q        <= ex_d;
      m_q         <= m_d;
      wb_q        <= wb_d;
      vala_q      <= vala_d;
      valb_q      <= valb_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Compared against the instruction currently in decode, so it must not wait for an edge.
  assign o_load_use = valid_q & m_q[MEMRD_BIT] & (dst_q != REG_ZERO) &
                      ((dst_q == i_rs) | (dst_q == i_rt));

  assign o_rs        = rs_q;
  assign o_rt        = rt_q;
  assign o_rd        = rd_q;
  assign o_ex        = ex_q;
  assign o_m         = m_q;
  assign o_wb        = wb_q;
  assign o_valA      = vala_q;
  assign o_valB      = valb_q;
  assign o_imm       = imm_q;
  assign o_pc_plus4  = pc4_q;
  assign o_operation = op_q;
  assign o_dst       = dst_q;
  assign o_valid     = valid_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: two instances (16-bit and 2-bit counters) share
// randomized and directed stimulus; a monitor compares against a behavioural model.
module tb_id_ex_pipe;

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic [1:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] va, vb, imm, pc;
    logic [5:0]  op;
    logic [4:0]  dst;
    logic        valid;
  } stage_t;

  typedef struct packed {
    stage_t      st;
    logic        lu;
    logic [15:0] sc, fc;
    logic [1:0]  sc2, fc2;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0, i_cnt_clr = 1'b0;
  logic [4:0]  i_rs = 5'd0, i_rt = 5'd0, i_rd = 5'd0;
  logic [1:0]  i_ex = 2'd0, i_wb = 2'd0;
  logic [2:0]  i_m = 3'd0;
  logic [31:0] i_valA = 32'd0, i_valB = 32'd0, i_imm = 32'd0, i_pc_plus4 = 32'd0;
  logic [5:0]  i_operation = 6'd0;

  logic [4:0]  a_rs, a_rt, a_rd, a_dst, b_rs, b_rt, b_rd, b_dst;
  logic [1:0]  a_ex, a_wb, b_ex, b_wb;
  logic [2:0]  a_m, b_m;
  logic [31:0] a_va, a_vb, a_imm, a_pc, b_va, b_vb, b_imm, b_pc;
  logic [5:0]  a_op, b_op;
  logic        a_valid, a_lu, b_valid, b_lu;
  logic [15:0] a_sc, a_fc;
  logic [1:0]  b_sc, b_fc;

  int total = 0;
  int bad = 0;
  exp_t sbq[$];

  stage_t model_st;
  int     m_sc, m_fc, m_sc2, m_fc2;

  always #5 clk = ~clk;

  id_ex_pipe u1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_cnt_clr(i_cnt_clr), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ex(i_ex), .i_m(i_m),
    .i_wb(i_wb), .i_valA(i_valA), .i_valB(i_valB), .i_imm(i_imm), .i_pc_plus4(i_pc_plus4),
    .i_operation(i_operation), .o_rs(a_rs), .o_rt(a_rt), .o_rd(a_rd), .o_ex(a_ex), .o_m(a_m),
    .o_wb(a_wb), .o_valA(a_va), .o_valB(a_vb), .o_imm(a_imm), .o_pc_plus4(a_pc),
    .o_operation(a_op), .o_dst(a_dst), .o_valid(a_valid), .o_load_use(a_lu),
    .o_stall_cnt(a_sc), .o_flush_cnt(a_fc)
  );

  id_ex_pipe #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_cnt_clr(i_cnt_clr), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_ex(i_ex), .i_m(i_m),
    .i_wb(i_wb), .i_valA(i_valA), .i_valB(i_valB), .i_imm(i_imm), .i_pc_plus4(i_pc_plus4),
    .i_operation(i_operation), .o_rs(b_rs), .o_rt(b_rt), .o_rd(b_rd), .o_ex(b_ex), .o_m(b_m),
    .o_wb(b_wb), .o_valA(b_va), .o_valB(b_vb), .o_imm(b_imm), .o_pc_plus4(b_pc),
    .o_operation(b_op), .o_dst(b_dst), .o_valid(b_valid), .o_load_use(b_lu),
    .o_stall_cnt(b_sc), .o_flush_cnt(b_fc)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic stage_t bubble();
    stage_t s;
    s = '0;
    s.op = 6'h3F;
    return s;
  endfunction

  function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rd);
    if (op inside {6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101, 6'b001111, 6'b100011})
      return rt;
    else if (op == 6'b000011)
      return 5'd31;
    else
      return rd;
  endfunction

  // Drive one cycle of stimulus at the falling edge and push the expected post-edge state.
  task automatic drive(input logic v, input logic s, input logic f, input logic c,
                       input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [2:0] m);
    exp_t e;
    @(negedge clk);
    i_valid = v; i_stall = s; i_flush = f; i_cnt_clr = c;
    i_operation = op; i_rs = rs; i_rt = rt; i_rd = rd; i_m = m;
    i_ex = 2'($urandom); i_wb = 2'($urandom);
    i_valA = $urandom; i_valB = $urandom; i_imm = $urandom; i_pc_plus4 = $urandom;
    if (f) model_st = bubble();
    else if (!s) begin
      if (v) model_st = '{rs: rs, rt: rt, rd: rd, ex: i_ex, m: m, wb: i_wb, va: i_valA,
                          vb: i_valB, imm: i_imm, pc: i_pc_plus4, op: op,
                          dst: dest_of(op, rt, rd), valid: 1'b1};
      else model_st = bubble();
    end
    if (c) begin
      m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    end else if (f) begin
      m_fc = (m_fc < 65535) ? m_fc + 1 : m_fc;
      m_fc2 = (m_fc2 < 3) ? m_fc2 + 1 : m_fc2;
    end else if (s) begin
      m_sc = (m_sc < 65535) ? m_sc + 1 : m_sc;
      m_sc2 = (m_sc2 < 3) ? m_sc2 + 1 : m_sc2;
    end
    e.st  = model_st;
    e.lu  = model_st.valid && model_st.m[1] && (model_st.dst != 5'd0) &&
            (model_st.dst == rs || model_st.dst == rt);
    e.sc  = 16'(m_sc);  e.fc  = 16'(m_fc);
    e.sc2 = 2'(m_sc2);  e.fc2 = 2'(m_fc2);
    sbq.push_back(e);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic v, input logic s, input logic f, input logic c,
                    input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd, input logic [2:0] m);
    drive(v, s, f, c, op, rs, rt, rd, m);
    edge_wait();
  endtask

  // Monitor: one expected entry per clock edge that followed a drive.
  initial begin
    exp_t e;
    stage_t sa, sb;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        sa = {a_rs, a_rt, a_rd, a_ex, a_m, a_wb, a_va, a_vb, a_imm, a_pc, a_op, a_dst, a_valid};
        sb = {b_rs, b_rt, b_rd, b_ex, b_m, b_wb, b_va, b_vb, b_imm, b_pc, b_op, b_dst, b_valid};
        chk("u1_stage", 192'(sa), 192'(e.st));
        chk("u2_stage", 192'(sb), 192'(e.st));
        chk("u1_load_use", 192'(a_lu), 192'(e.lu));
        chk("u2_load_use", 192'(b_lu), 192'(e.lu));
        chk("u1_counters", 192'({a_sc, a_fc}), 192'({e.sc, e.fc}));
        chk("u2_counters", 192'({b_sc, b_fc}), 192'({e.sc2, e.fc2}));
      end
    end
  end

  task automatic reset_check(input string tag);
    stage_t sa;
    rst = 1'b1;
    #1;
    sa = {a_rs, a_rt, a_rd, a_ex, a_m, a_wb, a_va, a_vb, a_imm, a_pc, a_op, a_dst, a_valid};
    chk({tag, "_stage"}, 192'(sa), 192'(bubble()));
    chk({tag, "_op"}, 192'(a_op), 192'(6'h3F));
    chk({tag, "_cnt"}, 192'({a_sc, a_fc, b_sc, b_fc}), 192'(0));
    chk({tag, "_lu"}, 192'(a_lu), 192'(0));
    model_st = bubble();
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [11];
    ops = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h03, 6'h2B, 6'h04};
    model_st = bubble();
    m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
    repeat (2) @(posedge clk);
    #2;
    reset_check("rst_init");

    go(1, 0, 0, 0, 6'b001000, 5'd2, 5'd5, 5'd9, 3'b000);
    chk("dst_addi", 192'(a_dst), 192'(5));
    chk("rd_raw_addi", 192'(a_rd), 192'(9));
    go(1, 0, 0, 0, 6'b000000, 5'd1, 5'd2, 5'd9, 3'b000);
    chk("dst_rtype", 192'(a_dst), 192'(9));
    go(1, 0, 0, 0, 6'b000011, 5'd1, 5'd2, 5'd4, 3'b000);
    chk("dst_jal", 192'(a_dst), 192'(31));

    go(1, 0, 0, 0, 6'b100011, 5'd3, 5'd7, 5'd12, 3'b010);
    drive(1, 0, 0, 0, 6'b000000, 5'd7, 5'd1, 5'd2, 3'b000);
    #1 chk("lu_hit", 192'(a_lu), 192'(1));
    edge_wait();
    go(1, 0, 0, 0, 6'b100011, 5'd3, 5'd0, 5'd12, 3'b010);
    drive(1, 0, 0, 0, 6'b000000, 5'd0, 5'd0, 5'd2, 3'b000);
    #1 chk("lu_zero_dst", 192'(a_lu), 192'(0));
    edge_wait();
    go(1, 0, 0, 0, 6'b000000, 5'd1, 5'd2, 5'd7, 3'b000);
    drive(1, 0, 0, 0, 6'b000000, 5'd7, 5'd7, 5'd2, 3'b000);
    #1 chk("lu_nonload", 192'(a_lu), 192'(0));
    edge_wait();

    go(1, 0, 0, 1, 6'b001101, 5'd4, 5'd6, 5'd8, 3'b001);
    repeat (3) go(1, 1, 0, 0, 6'b000000, 5'd10, 5'd11, 5'd12, 3'b111);
    chk("stall_hold_op", 192'({a_op, a_dst, a_valid}), 192'({6'b001101, 5'd6, 1'b1}));
    chk("stall_cnt3", 192'(a_sc), 192'(3));
    go(1, 1, 1, 0, 6'b000000, 5'd10, 5'd11, 5'd12, 3'b111);
    chk("flush_bubble", 192'({a_op, a_valid, a_dst, a_m}), 192'({6'h3F, 1'b0, 5'd0, 3'd0}));
    chk("flush_cnts", 192'({a_fc, a_sc}), 192'({16'd1, 16'd3}));
    go(0, 0, 0, 0, 6'b001000, 5'd3, 5'd4, 5'd5, 3'b111);
    chk("invalid_bubble", 192'({a_op, a_valid, a_rs, a_m}), 192'({6'h3F, 1'b0, 5'd0, 3'd0}));

    go(0, 0, 0, 1, 6'b000000, 5'd0, 5'd0, 5'd0, 3'b000);
    repeat (5) go(1, 1, 0, 0, 6'b100011, 5'd1, 5'd2, 5'd3, 3'b010);
    chk("sat_cnt2", 192'(b_sc), 192'(3));
    chk("cnt16_five", 192'(a_sc), 192'(5));
    go(1, 1, 0, 1, 6'b100011, 5'd1, 5'd2, 5'd3, 3'b010);
    chk("clr_beats_inc", 192'({a_sc, b_sc}), 192'(0));

    go(1, 0, 0, 0, 6'b100011, 5'd1, 5'd9, 5'd3, 3'b010);
    drive(1, 1, 0, 0, 6'b000000, 5'd9, 5'd2, 5'd3, 3'b000);
    edge_wait();
    reset_check("rst_midstall");

    for (int k = 0; k < 400; k++) begin
      go(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
         ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
         ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
         ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
         ops[$urandom_range(0, 10)],
         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         3'($urandom));
    end

    repeat (2) edge_wait();
    chk("scoreboard_drained", 192'(sbq.size()), 192'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register with valid tracking, stall hold, synchronous flush (bubble insertion), destination-register resolution and load-use hazard detection. It sits between the decode stage and the execute stage of the MIPS core. It replaces the fixed-width ID/EX latch, and adds saturating stall/flush event counters for performance monitoring.

## Interface
- XLEN, 32, width of operand, immediate and PC datapaths
- REG_W, 5, register-index width
- OP_W, 6, opcode width
- NOP_OP, 6'b111111, opcode loaded on reset/bubble
- MEMRD_BIT, 1, bit of the M control field that marks a memory read (load)
- CNT_W, 16, event-counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  decode stage presents a real instruction
- i_stall  in  1  hold all stage contents
- i_flush  in  1  load a bubble
- i_cnt_clr  in  1  synchronous clear of both counters
- i_rs, i_rt, i_rd  in  REG_W each  decoded register indices
- i_ex  in  2  EX control
- i_m  in  3  MEM control
- i_wb  in  2  WB control
- i_valA, i_valB, i_imm, i_pc_plus4  in  XLEN each  operands, sign-extended immediate, PC+4
- i_operation  in  OP_W  opcode
- o_rs, o_rt, o_rd, o_ex, o_m, o_wb, o_valA, o_valB, o_imm, o_pc_plus4, o_operation  out  same widths  registered copies
- o_dst  out  REG_W  resolved destination register
- o_valid  out  1  stage holds a real instruction
- o_load_use  out  1  load-use hazard against the incoming instruction (combinational)
- o_stall_cnt, o_flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Per-edge priority: rst > i_flush > i_stall > load.
- Load (no flush, no stall):
  - Every o_* field takes the matching i_*.
  - o_valid <= i_valid.
  - If i_valid=0, the stage loads a bubble instead.
- Bubble (flush, or load with i_valid=0):
  - o_ex, o_m and o_wb = 0.
  - o_operation = NOP_OP.
  - o_valid = 0.
  - All index and data fields = 0.
  - o_dst = 0.
- Stall: every register holds, including o_valid and o_dst.
- Flush while stalled: the flush wins and a bubble is loaded.
- Destination resolution, registered with the other fields:
  - i_operation in {001000 addi, 001001 addiu, 001010 slti, 001100 andi, 001101 ori, 001111 lui, 100011 lw}: o_dst = i_rt.
  - i_operation = 000011 jal: o_dst = 31.
  - Otherwise: o_dst = i_rd.
  - o_rd is always a raw copy of i_rd.
- o_load_use = o_valid & o_m[MEMRD_BIT] & (o_dst != 0) & ((o_dst == i_rs) | (o_dst == i_rt)).
  - Purely combinational from the registered stage and the current inputs.
  - It is not gated by i_stall or i_flush; the hazard unit uses it to drive i_stall upstream.
- Counters:
  - o_stall_cnt increments on each edge with i_stall=1 and i_flush=0.
  - o_flush_cnt increments on each edge with i_flush=1.
  - Both saturate at 2^CNT_W-1, with no wrap-around.
  - i_cnt_clr zeroes both counters on that edge; clear beats increment.
  - Counters ignore pipeline state otherwise.

## Timing
- Reset, asynchronous and immediate:
  - All fields, o_dst, o_valid and both counters = 0.
  - o_operation = NOP_OP.
  - o_load_use therefore = 0.
- Latency: one cycle from input to o_* (including o_dst and o_valid).
- o_load_use has zero latency from i_rs/i_rt.
- A reset mid-stall or mid-flush drops the held contents. The first edge after rst falls applies normal priority.
- A stall asserted for N cycles keeps outputs bit-identical for N edges, and o_stall_cnt advances by N (unless saturated).
- Simultaneous i_cnt_clr and an increment condition leaves the counter at 0 after the edge.

## Test plan
- Reset: assert rst mid-cycle with arbitrary state -> outputs are 0 immediately, o_operation=6'h3F, counters=0.
- Destination resolution:
  - addi (001000) with rs=2, rt=5, rd=9 -> o_dst=5.
  - R-type (000000) with rd=9 -> o_dst=9.
  - jal -> o_dst=31.
- Load-use:
  - lw with rt=7 latched, then incoming rs=7 -> o_load_use=1.
  - Same case with rt=0 -> o_load_use=0.
  - A non-load to the same register -> 0.
- Stall/flush:
  - Stall 3 cycles -> outputs held, o_stall_cnt=3.
  - Flush while stalled -> bubble, o_valid=0, o_flush_cnt=1, o_stall_cnt unchanged.
- Invalid input: i_valid=0 with non-zero fields -> bubble loaded, o_operation=6'h3F.
- Saturation: CNT_W=2, stall 5 cycles -> o_stall_cnt=3. Then i_cnt_clr together with a stall -> 0.
